io_pin_conditioner: RTL and testbench

//  Pad-side stage directly upstream of io_filter. Synchronises and debounces raw input pads into io_filter's pin_data_in.

---
 rtl/io_pin_conditioner.sv | 101 ++++++++++
 tb/tb_io_pin_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_pin_conditioner.sv
// io_pin_conditioner: pad-side synchroniser, debouncer and output register
// stage sitting directly in front of io_filter.
module io_pin_conditioner #(
  parameter int IO_PINS       = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DEBOUNCE_BITS-1:0] debounce_limit,
  input  logic [IO_PINS-1:0]       pin_dir,
  input  logic [IO_PINS-1:0]       io_in,
  output logic [IO_PINS-1:0]       io_out,
  output logic [IO_PINS-1:0]       io_oeb,
  output logic [IO_PINS-1:0]       filt_data_in,
  input  logic [IO_PINS-1:0]       filt_data_out
);

  typedef logic [DEBOUNCE_BITS-1:0] cnt_t;

  logic [SYNC_STAGES-1:0][IO_PINS-1:0] sync_q;
  logic [SYNC_STAGES-1:0][IO_PINS-1:0] sync_d;
  logic [IO_PINS-1:0]                  syn;

  logic [IO_PINS-1:0]       stable_q;
  logic [IO_PINS-1:0]       stable_d;
  cnt_t [IO_PINS-1:0]       cnt_q;
  cnt_t [IO_PINS-1:0]       cnt_d;

  logic [IO_PINS-1:0]       io_out_q;
  logic [IO_PINS-1:0]       io_out_d;
  logic [IO_PINS-1:0]       io_oeb_q;
  logic [IO_PINS-1:0]       io_oeb_d;

  // Shift every pad through the chain; stage 0 takes the raw pads.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], io_in};
  end

  assign syn = sync_q[SYNC_STAGES-1];

  // Synchroniser flops, cleared to 0 on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Per-pin debounce: accept a new level only after it outlasts the limit.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < IO_PINS; i++) begin
      if (pin_dir[i]) begin
        cnt_d[i] = '0;
      end else if (syn[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < debounce_limit) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else begin
        stable_d[i] = syn[i];
        cnt_d[i]    = '0;
      end
    end
  end

  // Debounce state: accepted level plus per-pin stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output data follows io_filter; enable is active-low of pin_dir.
  always_comb begin
    io_out_d = filt_data_out;
    io_oeb_d = ~pin_dir;
  end

  // Pad registers; reset leaves every pad undriven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out_q <= '0;
      io_oeb_q <= '1;
    end else begin
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
    end
  end

  assign filt_data_in = stable_q;
  assign io_out       = io_out_q;
  assign io_oeb       = io_oeb_q;

endmodule

// File: tb/tb_io_pin_conditioner.sv
// tb_io_pin_conditioner: directed vectors feed a scoreboard queue;
// a monitor pops and compares entries when their due cycle arrives.
module tb_io_pin_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  bit          clk_en = 1'b0;
  logic [3:0]  lim = 4'd0;
  logic [15:0] dir = 16'h0;
  logic [15:0] io_in = 16'h0;
  logic [15:0] fdo = 16'h0;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic [15:0] fdi;

  io_pin_conditioner #(
    .IO_PINS(16),
    .SYNC_STAGES(2),
    .DEBOUNCE_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .debounce_limit(lim),
    .pin_dir(dir),
    .io_in(io_in),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .filt_data_in(fdi),
    .filt_data_out(fdo)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    string       nm;
    int          sel;
    int          at;
    logic [15:0] m;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event imm_ev;

  task automatic sb_push(string nm, int sel, int k,
                         logic [15:0] m, logic [15:0] v);
    exp_t e;
    e.nm  = nm;
    e.sel = sel;
    e.at  = (k < 0) ? -1 : cyc + k;
    e.m   = m;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic scan();
    logic [15:0] act;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc || q[i].at < 0) begin
        case (q[i].sel)
          0:       act = fdi;
          1:       act = io_out;
          default: act = io_oeb;
        endcase
        n_cmp++;
        if ((act & q[i].m) !== (q[i].v & q[i].m)) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h mask=%h",
                   q[i].nm, cyc, act, q[i].v, q[i].m);
        end
        q.delete(i);
      end
    end
  endtask

  always @(negedge clk) scan();
  always @(imm_ev) scan();

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Async reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    sb_push("rst_filt", 0, -1, 16'hFFFF, 16'h0000);
    sb_push("rst_out",  1, -1, 16'hFFFF, 16'h0000);
    sb_push("rst_oeb",  2, -1, 16'hFFFF, 16'hFFFF);
    ->imm_ev;
    #1 rst = 1'b0;
    #1 clk_en = 1'b1;
    @(negedge clk);

    // Idle after release: nothing moves.
    io_in = 16'h0;
    sb_push("idle_filt", 0, 3, 16'hFFFF, 16'h0000);
    sb_push("idle_out",  1, 3, 16'hFFFF, 16'h0000);
    sb_push("idle_oeb",  2, 3, 16'hFFFF, 16'hFFFF);
    step(4);

    // Limit 0: three-edge latency on pin 3.
    lim = 4'd0;
    io_in = 16'h0008;
    sb_push("lat_e2", 0, 2, 16'h0008, 16'h0000);
    sb_push("lat_e3", 0, 3, 16'h0008, 16'h0008);
    step(4);
    io_in = 16'h0000;
    sb_push("fall_e2", 0, 2, 16'h0008, 16'h0008);
    sb_push("fall_e3", 0, 3, 16'h0008, 16'h0000);
    step(4);

    // Limit 4: a 4-cycle pulse is rejected.
    lim = 4'd4;
    sb_push("rej_e4",  0, 4,  16'h0001, 16'h0000);
    sb_push("rej_e7",  0, 7,  16'h0001, 16'h0000);
    sb_push("rej_e10", 0, 10, 16'h0001, 16'h0000);
    io_in = 16'h0001;
    step(4);
    io_in = 16'h0000;
    step(8);

    // Limit 4: held level accepted after edge 7.
    sb_push("acc_e6", 0, 6, 16'h0001, 16'h0000);
    sb_push("acc_e7", 0, 7, 16'h0001, 16'h0001);
    io_in = 16'h0001;
    step(8);
    io_in = 16'h0000;
    sb_push("accf_e6", 0, 6, 16'h0001, 16'h0001);
    sb_push("accf_e7", 0, 7, 16'h0001, 16'h0000);
    step(9);

    // Output pin 5: drive path and loopback immunity.
    lim = 4'd0;
    dir = 16'h0020;
    fdo = 16'h0020;
    sb_push("drv_out", 1, 1, 16'h0020, 16'h0020);
    sb_push("drv_oeb", 2, 1, 16'hFFFF, 16'hFFDF);
    step(2);
    fdo = 16'hA5C3;
    sb_push("out_pat", 1, 1, 16'hFFFF, 16'hA5C3);
    sb_push("loop_10", 0, 10, 16'hFFFF, 16'h0000);
    sb_push("loop_20", 0, 20, 16'hFFFF, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      io_in[5] = ~io_in[5];
      step(1);
    end
    io_in = 16'h0000;
    step(3);

    // Limit lowered mid-count: accept on the next edge.
    dir = 16'h0000;
    lim = 4'd8;
    io_in = 16'h0004;
    sb_push("in_oeb", 2, 1, 16'hFFFF, 16'hFFFF);
    sb_push("low_e7", 0, 7, 16'h0004, 16'h0000);
    sb_push("low_e8", 0, 8, 16'h0004, 16'h0004);
    step(7);
    lim = 4'd3;
    step(3);

    // Async reset mid-count on pin 7, then full restart.
    dir = 16'h0010;
    fdo = 16'h1234;
    lim = 4'd6;
    io_in = 16'h0084;
    sb_push("pre_oeb", 2, 1, 16'hFFFF, 16'hFFEF);
    sb_push("pre_out", 1, 1, 16'hFFFF, 16'h1234);
    sb_push("pre_fdi", 0, 1, 16'hFFFF, 16'h0004);
    step(5);
    #2 rst = 1'b1;
    #1;
    sb_push("mid_filt", 0, -1, 16'hFFFF, 16'h0000);
    sb_push("mid_out",  1, -1, 16'hFFFF, 16'h0000);
    sb_push("mid_oeb",  2, -1, 16'hFFFF, 16'hFFFF);
    ->imm_ev;
    #1 rst = 1'b0;
    sb_push("post_oeb", 2, 1, 16'hFFFF, 16'hFFEF);
    sb_push("post_out", 1, 1, 16'hFFFF, 16'h1234);
    sb_push("post_e8",  0, 8, 16'h0084, 16'h0000);
    sb_push("post_e9",  0, 9, 16'h0084, 16'h0084);
    step(12);

    // Drain any outstanding expectations within a bounded window.
    for (int i = 0; i < 30 && q.size() > 0; i++) step(1);
    while (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s never compared (due cyc=%0d)",
               q[0].nm, q[0].at);
      void'(q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
